// File: rtl/game_pkg.sv
// Shared definitions for the memory game sequencer.
// Holds the round-controller state encoding and the common field widths
// used by the top-level FSM and the sequence memory.
package game_pkg;

    localparam int unsigned DIGIT_W = 2;   // one game symbol (4 symbols)
    localparam int unsigned LEN_W   = 4;   // sequence length / index width
    localparam int unsigned TMR_W   = 32;  // phase and idle timers

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GEN      = 3'd1,
        ST_SHOW_ON  = 3'd2,
        ST_SHOW_GAP = 3'd3,
        ST_WAIT_IN  = 3'd4,
        ST_WIN      = 3'd5,
        ST_LOSE     = 3'd6
    } state_e;

endpackage

// File: rtl/seq_mem.sv
// Sequence storage for the memory game.
// DEPTH x DIGIT_W register file with one synchronous write port and one
// asynchronous read port. Contents are not reset; every entry is written
// before it is read.
// Ports:
//   clk_i    in  clock, rising edge
//   we_i     in  write enable
//   waddr_i  in  write address
//   wdata_i  in  write data
//   raddr_i  in  read address
//   rdata_o  out read data (0 for an out-of-range address)
module seq_mem
    import game_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [LEN_W-1:0]   waddr_i,
    input  logic [DIGIT_W-1:0] wdata_i,
    input  logic [LEN_W-1:0]   raddr_i,
    output logic [DIGIT_W-1:0] rdata_o
);

    logic [DIGIT_W-1:0] mem_q [DEPTH];

    // Address decode by comparison keeps the address width independent of
    // DEPTH, which need not be a power of two.
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (we_i && (waddr_i == LEN_W'(i))) begin
                mem_q[i] <= wdata_i;
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (raddr_i == LEN_W'(i)) begin
                rdata_o = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/memory_game_sequencer.sv
// Round controller for the 4-symbol memory game.
// Each round appends one sampled random digit to the stored sequence,
// replays the whole sequence on the display path, then checks the player's
// presses against it. Reaching MAX_LEN correct digits wins; a wrong press
// loses.
// Optional feature: define INPUT_TIMEOUT_EN to add a per-press idle timer
// in WAIT_IN (TIMEOUT_CYC clocks without a press loses the game).
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   start      in   1-clk pulse: begin new game (ignored while busy)
//   rand_num   in   current digit from the random generator
//   btn_valid  in   1-clk pulse: player pressed a button
//   btn_digit  in   digit of that press
//   led_valid  out  display digit now (SHOW phase only)
//   led_digit  out  digit to display, 0 when led_valid is low
//   busy       out  high outside IDLE/WIN/LOSE
//   round_len  out  current sequence length
//   win        out  level, held until next start
//   lose       out  level, held until next start
module memory_game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned MAX_LEN     = 8,
    parameter int unsigned SHOW_CYCLES = 25000000,
    parameter int unsigned GAP_CYCLES  = 12500000,
    parameter int unsigned TIMEOUT_CYC = 250000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [DIGIT_W-1:0] rand_num,
    input  logic               btn_valid,
    input  logic [DIGIT_W-1:0] btn_digit,
    output logic               led_valid,
    output logic [DIGIT_W-1:0] led_digit,
    output logic               busy,
    output logic [LEN_W-1:0]   round_len,
    output logic               win,
    output logic               lose
);

`ifdef INPUT_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    localparam logic [TMR_W-1:0] SHOW_LAST = TMR_W'(SHOW_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               win_q, win_d;
    logic               lose_q, lose_d;

    logic               mem_we;
    logic [DIGIT_W-1:0] mem_rdata;
    logic               last_idx;

    seq_mem #(
        .DEPTH (MAX_LEN)
    ) u_seq_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (len_q),
        .wdata_i (rand_num),
        .raddr_i (idx_q),
        .rdata_o (mem_rdata)
    );

    assign last_idx = (idx_q == (len_q - LEN_W'(1)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            tmr_q   <= '0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        win_d   = win_q;
        lose_d  = lose_q;
        mem_we  = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (start) begin
                    len_d   = '0;
                    win_d   = 1'b0;
                    lose_d  = 1'b0;
                    state_d = ST_GEN;
                end
            end
            ST_GEN: begin
                mem_we  = 1'b1;
                len_d   = len_q + LEN_W'(1);
                idx_d   = '0;
                tmr_d   = '0;
                state_d = ST_SHOW_ON;
            end
            ST_SHOW_ON: begin
                if (tmr_q == SHOW_LAST) begin
                    tmr_d   = '0;
                    state_d = ST_SHOW_GAP;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_SHOW_GAP: begin
                // Clearing the timer here also starts the WAIT_IN idle
                // timer from zero on entry.
                if (tmr_q == GAP_LAST) begin
                    tmr_d = '0;
                    if (last_idx) begin
                        idx_d   = '0;
                        state_d = ST_WAIT_IN;
                    end else begin
                        idx_d   = idx_q + LEN_W'(1);
                        state_d = ST_SHOW_ON;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_WAIT_IN: begin
                // A press in the same cycle as the timeout takes priority.
                if (btn_valid) begin
                    tmr_d = '0;
                    if (btn_digit != mem_rdata) begin
                        lose_d  = 1'b1;
                        state_d = ST_LOSE;
                    end else if (!last_idx) begin
                        idx_d = idx_q + LEN_W'(1);
                    end else if (len_q == LEN_MAX) begin
                        win_d   = 1'b1;
                        state_d = ST_WIN;
                    end else begin
                        state_d = ST_GEN;
                    end
                end else if (TIMEOUT_ON) begin
                    if (tmr_q == TO_LAST) begin
                        lose_d  = 1'b1;
                        state_d = ST_LOSE;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode directly from registered state so that an asynchronous
    // reset clears them immediately, without waiting for a clock edge.
    assign led_valid = (state_q == ST_SHOW_ON);
    assign led_digit = led_valid ? mem_rdata : '0;
    assign busy      = !((state_q == ST_IDLE) || (state_q == ST_WIN) ||
                         (state_q == ST_LOSE));
    assign round_len = len_q;
    assign win       = win_q;
    assign lose      = lose_q;

endmodule

// File: tb/tb_memory_game_sequencer.sv
module tb_memory_game_sequencer;

    localparam int unsigned MAXL = 3;
    localparam int unsigned SHOW = 4;
    localparam int unsigned GAP  = 2;
    localparam int unsigned TO   = 20;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic       start     = 1'b0;
    logic [1:0] rand_num  = 2'd0;
    logic       btn_valid = 1'b0;
    logic [1:0] btn_digit = 2'd0;
    logic       led_valid;
    logic [1:0] led_digit;
    logic       busy;
    logic [3:0] round_len;
    logic       win;
    logic       lose;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] seq [MAXL];
    logic [9:0] obs;

    memory_game_sequencer #(
        .MAX_LEN     (MAXL),
        .SHOW_CYCLES (SHOW),
        .GAP_CYCLES  (GAP),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rand_num  (rand_num),
        .btn_valid (btn_valid),
        .btn_digit (btn_digit),
        .led_valid (led_valid),
        .led_digit (led_digit),
        .busy      (busy),
        .round_len (round_len),
        .win       (win),
        .lose      (lose)
    );

    always #5 clk = ~clk;

    assign obs = {led_valid, led_digit, busy, round_len, win, lose};

    function automatic logic [9:0] ov(input logic lv, input logic [1:0] ld,
                                      input logic b, input logic [3:0] rl,
                                      input logic w, input logic l);
        return {lv, ld, b, rl, w, l};
    endfunction

    task automatic chk(input string tag, input logic [9:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed {lv,ld,busy,len,win,lose}=%b required %b",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [1:0] d);
        btn_valid = 1'b1;
        btn_digit = d;
        tick();
        btn_valid = 1'b0;
        btn_digit = 2'd0;
    endtask

    // Leaves the bench in the GEN cycle.
    task automatic start_game(input logic [1:0] r);
        rand_num = r;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Entered on the first SHOW_ON cycle; leaves on the first WAIT_IN cycle.
    task automatic replay(input int unsigned len);
        for (int unsigned i = 0; i < len; i++) begin
            for (int unsigned c = 0; c < SHOW; c++) begin
                chk("show", ov(1'b1, seq[i], 1'b1, 4'(len), 1'b0, 1'b0));
                tick();
            end
            for (int unsigned c = 0; c < GAP; c++) begin
                chk("gap", ov(1'b0, 2'd0, 1'b1, 4'(len), 1'b0, 1'b0));
                tick();
            end
        end
        chk("wait_entry", ov(1'b0, 2'd0, 1'b1, 4'(len), 1'b0, 1'b0));
    endtask

    initial begin
        seq[0] = 2'd2;
        seq[1] = 2'd1;
        seq[2] = 2'd3;

        // Reset state and idle behaviour.
        repeat (3) tick();
        chk("reset_state", '0);
        reset = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if ((k % 10) == 3) begin
                btn_valid = 1'b1;
                btn_digit = 2'(k);
            end
            tick();
            btn_valid = 1'b0;
            if ((k % 10) == 4) chk("idle_ignore_btn", '0);
        end

        // Winning game: rounds 2, 1, 3 replayed correctly.
        start_game(2'd2);
        chk("gen_r1", ov(1'b0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0));
        tick();
        replay(1);
        repeat (10) tick();
        chk("wait_r1_hold", ov(1'b0, 2'd0, 1'b1, 4'd1, 1'b0, 1'b0));
        rand_num = 2'd1;
        press(2'd2);
        chk("gen_r2", ov(1'b0, 2'd0, 1'b1, 4'd1, 1'b0, 1'b0));
        tick();
        replay(2);
        rand_num = 2'd3;
        press(2'd2);
        chk("wait_r2_mid", ov(1'b0, 2'd0, 1'b1, 4'd2, 1'b0, 1'b0));
        press(2'd1);
        chk("gen_r3", ov(1'b0, 2'd0, 1'b1, 4'd2, 1'b0, 1'b0));
        tick();
        replay(3);
        press(2'd2);
        press(2'd1);
        press(2'd3);
        chk("win", ov(1'b0, 2'd0, 1'b0, 4'd3, 1'b1, 1'b0));
        press(2'd0);
        chk("win_hold", ov(1'b0, 2'd0, 1'b0, 4'd3, 1'b1, 1'b0));

        // Losing game: wrong digit in round 2.
        start_game(2'd2);
        chk("gen_clears_win", ov(1'b0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0));
        tick();
        replay(1);
        rand_num = 2'd1;
        press(2'd2);
        chk("gen_r2b", ov(1'b0, 2'd0, 1'b1, 4'd1, 1'b0, 1'b0));
        tick();
        replay(2);
        press(2'd2);
        chk("wait_r2b_mid", ov(1'b0, 2'd0, 1'b1, 4'd2, 1'b0, 1'b0));
        press(2'd0);
        chk("lose", ov(1'b0, 2'd0, 1'b0, 4'd2, 1'b0, 1'b1));
        press(2'd1);
        chk("lose_hold", ov(1'b0, 2'd0, 1'b0, 4'd2, 1'b0, 1'b1));
        start_game(2'd2);
        chk("gen_clears_lose", ov(1'b0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0));

        // Asynchronous reset during SHOW_ON.
        tick();
        chk("show_before_rst", ov(1'b1, 2'd2, 1'b1, 4'd1, 1'b0, 1'b0));
        tick();
        #1;
        reset = 1'b0;
        #1;
        chk("rst_async", '0);
        tick();
        chk("rst_held", '0);
        reset = 1'b1;
        tick();
        chk("idle_after_rst", '0);

`ifdef INPUT_TIMEOUT_EN
        // No press for TO cycles loses.
        seq[0] = 2'd1;
        start_game(2'd1);
        tick();
        replay(1);
        repeat (TO - 1) tick();
        chk("no_timeout_yet", ov(1'b0, 2'd0, 1'b1, 4'd1, 1'b0, 1'b0));
        tick();
        chk("timeout_lose", ov(1'b0, 2'd0, 1'b0, 4'd1, 1'b0, 1'b1));

        // A press on the last allowed cycle is accepted.
        seq[0] = 2'd3;
        start_game(2'd3);
        chk("gen_to2", ov(1'b0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0));
        tick();
        replay(1);
        repeat (TO - 1) tick();
        rand_num = 2'd0;
        press(2'd3);
        chk("press_at_last_cycle", ov(1'b0, 2'd0, 1'b1, 4'd1, 1'b0, 1'b0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
